// File: rtl/decode_round_sequencer.sv
// decode_round_sequencer
//   Host-side controller for one decoding job on a Helios decoder over its
//   8-bit byte-stream interface. After reset it sends the start-decoding
//   message once, then for every job sends the measurement header and
//   streams MEAS_BYTES bytes fetched from the measurement RAM. It then
//   collects the result frame (iteration count, 16-bit cycle count,
//   CORR_BYTES correction bytes), writes the corrections to the correction
//   RAM and reports job_done, or timeout_err if the decoder goes quiet.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   job_start             one-cycle job request (accepted in IDLE only)
//   busy / job_done       job in progress / one-cycle completion pulse
//   timeout_err           sticky, cleared by the next accepted job_start
//   meas_rd_*             measurement RAM read port (1-cycle read latency)
//   tx_data/valid/ready   byte stream to the decoder input FIFO
//   rx_data/valid/ready   byte stream from the decoder output FIFO
//   corr_we/addr/data     correction RAM write port
//   iteration_count       iteration count of the last result frame
//   cycle_count           cycle count of the last result frame
module decode_round_sequencer #(
   parameter int         MEAS_BYTES     = 30,
   parameter int         CORR_BYTES     = 40,
   parameter logic [7:0] START_MSG      = 8'h01,
   parameter logic [7:0] MEAS_HEADER    = 8'h02,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter int         MA_W           = (MEAS_BYTES > 1) ? $clog2(MEAS_BYTES) : 1,
   parameter int         CA_W           = (CORR_BYTES > 1) ? $clog2(CORR_BYTES) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            job_start,
   output logic            busy,
   output logic            job_done,
   output logic            timeout_err,
   output logic            meas_rd_en,
   output logic [MA_W-1:0] meas_rd_addr,
   input  logic [7:0]      meas_rd_data,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            rx_ready,
   output logic            corr_we,
   output logic [CA_W-1:0] corr_addr,
   output logic [7:0]      corr_data,
   output logic [7:0]      iteration_count,
   output logic [15:0]     cycle_count
);

   // Index counters are one bit wider than the address when the byte count
   // is a power of two, so the "all issued" compare never sees a wrap.
   localparam int MC_W = $clog2(MEAS_BYTES + 1);
   localparam int CC_W = $clog2(CORR_BYTES + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [MC_W-1:0] MEAS_N    = MC_W'(MEAS_BYTES);
   localparam logic [MC_W-1:0] MEAS_LAST = MC_W'(MEAS_BYTES - 1);
   localparam logic [CC_W-1:0] CORR_LAST = CC_W'(CORR_BYTES - 1);
   localparam logic [TW-1:0]   TO_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE,
      SEND_START,
      SEND_HDR,
      SEND_MEAS,
      RX_ITER,
      RX_CYC_HI,
      RX_CYC_LO,
      RX_CORR,
      DONE
   } state_t;

   state_t          state;
   logic            start_sent;
   logic [MC_W-1:0] rd_idx;      // next RAM address to read
   logic [MC_W-1:0] tx_idx;      // measurement bytes transferred so far
   logic [CC_W-1:0] corr_idx;    // correction bytes accepted so far
   logic [TW-1:0]   to_cnt;      // idle cycles while awaiting a result byte

   // 2-entry prefetch FIFO between the RAM and tx
   logic [1:0][7:0] fifo_mem;
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      fifo_cnt;
   logic            rd_inflight; // read issued last cycle, data on meas_rd_data now

   logic            in_meas;
   logic            tx_fire;
   logic            meas_pop;
   logic            rx_fire;
   logic            to_hit;
   logic [2:0]      pending;

   assign in_meas  = (state == SEND_MEAS);
   assign tx_valid = (state == SEND_START) || (state == SEND_HDR) ||
                     (in_meas && (fifo_cnt != 2'd0));
   assign tx_fire  = tx_valid && tx_ready;
   assign meas_pop = in_meas && tx_fire;

   // Occupancy plus in-flight reads, less the byte leaving this cycle.
   // Counting the departing byte lets a new read replace it in the same
   // cycle, which is what sustains one byte per cycle under full ready.
   assign pending    = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, meas_pop};
   assign meas_rd_en = in_meas && (rd_idx < MEAS_N) && (pending < 3'd2);
   assign meas_rd_addr = rd_idx[MA_W-1:0];

   assign rx_ready = (state == RX_ITER) || (state == RX_CYC_HI) ||
                     (state == RX_CYC_LO) || (state == RX_CORR);
   assign rx_fire  = rx_valid && rx_ready;
   // Fires on the edge where the idle counter would reach TIMEOUT_CYCLES.
   assign to_hit   = rx_ready && !rx_fire && (to_cnt == TO_LAST);

   always_comb begin
      tx_data = 8'h00;
      case (state)
         SEND_START: tx_data = START_MSG;
         SEND_HDR:   tx_data = MEAS_HEADER;
         SEND_MEAS:  if (fifo_cnt != 2'd0) tx_data = fifo_mem[rd_ptr];
         default:    tx_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         start_sent      <= 1'b0;
         busy            <= 1'b0;
         job_done        <= 1'b0;
         timeout_err     <= 1'b0;
         rd_idx          <= '0;
         tx_idx          <= '0;
         corr_idx        <= '0;
         to_cnt          <= '0;
         fifo_mem        <= '0;
         wr_ptr          <= 1'b0;
         rd_ptr          <= 1'b0;
         fifo_cnt        <= 2'd0;
         rd_inflight     <= 1'b0;
         corr_we         <= 1'b0;
         corr_addr       <= '0;
         corr_data       <= 8'h00;
         iteration_count <= 8'h00;
         cycle_count     <= 16'h0000;
      end else begin
         job_done <= 1'b0;
         corr_we  <= 1'b0;

         // prefetch pipeline: issue -> land in FIFO -> pop to tx
         rd_inflight <= meas_rd_en;
         if (meas_rd_en) rd_idx <= rd_idx + 1'b1;
         if (rd_inflight) begin
            fifo_mem[wr_ptr] <= meas_rd_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (meas_pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, meas_pop};

         // saturating idle counter, only alive while awaiting result bytes
         if (!rx_ready || rx_fire) to_cnt <= '0;
         else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (job_start) begin
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
                  rd_idx      <= '0;
                  tx_idx      <= '0;
                  corr_idx    <= '0;
                  wr_ptr      <= 1'b0;
                  rd_ptr      <= 1'b0;
                  fifo_cnt    <= 2'd0;
                  state       <= start_sent ? SEND_HDR : SEND_START;
               end
            end
            SEND_START: begin
               if (tx_fire) begin
                  start_sent <= 1'b1;
                  state      <= SEND_HDR;
               end
            end
            SEND_HDR: begin
               if (tx_fire) state <= SEND_MEAS;
            end
            SEND_MEAS: begin
               if (meas_pop) begin
                  tx_idx <= tx_idx + 1'b1;
                  // every read has been issued and drained by now
                  if (tx_idx == MEAS_LAST) begin
                     tx_idx <= '0;
                     rd_idx <= '0;
                     state  <= RX_ITER;
                  end
               end
            end
            RX_ITER: begin
               if (rx_fire) begin
                  iteration_count <= rx_data;
                  state           <= RX_CYC_HI;
               end
            end
            RX_CYC_HI: begin
               if (rx_fire) begin
                  cycle_count[15:8] <= rx_data;
                  state             <= RX_CYC_LO;
               end
            end
            RX_CYC_LO: begin
               if (rx_fire) begin
                  cycle_count[7:0] <= rx_data;
                  state            <= RX_CORR;
               end
            end
            RX_CORR: begin
               if (rx_fire) begin
                  corr_we   <= 1'b1;
                  corr_addr <= corr_idx[CA_W-1:0];
                  corr_data <= rx_data;
                  corr_idx  <= corr_idx + 1'b1;
                  if (corr_idx == CORR_LAST) begin
                     corr_idx <= '0;
                     job_done <= 1'b1;   // high during the DONE cycle
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Decoder went quiet: abandon the job and force a fresh START_MSG
         // next time, since the decoder state is unknown.
         if (to_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            start_sent  <= 1'b0;
            corr_idx    <= '0;
            state       <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_decode_round_sequencer.sv
module tb_decode_round_sequencer;
   localparam int MEAS_BYTES = 30;
   localparam int CORR_BYTES = 40;
   localparam int TO_CYC     = 100;
   localparam int MA_W       = 5;
   localparam int CA_W       = 6;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            job_start = 1'b0;
   logic            busy, job_done, timeout_err;
   logic            meas_rd_en;
   logic [MA_W-1:0] meas_rd_addr;
   logic [7:0]      meas_rd_data = 8'h00;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready = 1'b0;
   logic [7:0]      rx_data = 8'h00;
   logic            rx_valid = 1'b0;
   logic            rx_ready;
   logic            corr_we;
   logic [CA_W-1:0] corr_addr;
   logic [7:0]      corr_data;
   logic [7:0]      iteration_count;
   logic [15:0]     cycle_count;

   int n_cmp = 0;
   int n_err = 0;
   int bad_rd = 0;

   logic [7:0]  ram [MEAS_BYTES];
   logic [7:0]  tx_q [$];
   logic [7:0]  rx_q [$];
   logic [15:0] corr_q [$];
   logic [7:0]  exp_iter;
   logic [15:0] exp_cyc;

   decode_round_sequencer #(
      .MEAS_BYTES(MEAS_BYTES), .CORR_BYTES(CORR_BYTES),
      .START_MSG(8'h01), .MEAS_HEADER(8'h02), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .reset(reset), .job_start(job_start),
      .busy(busy), .job_done(job_done), .timeout_err(timeout_err),
      .meas_rd_en(meas_rd_en), .meas_rd_addr(meas_rd_addr), .meas_rd_data(meas_rd_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .corr_we(corr_we), .corr_addr(corr_addr), .corr_data(corr_data),
      .iteration_count(iteration_count), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // measurement RAM model, one-cycle read latency
   always @(posedge clk) begin
      if (meas_rd_en) begin
         if (int'(meas_rd_addr) >= MEAS_BYTES) begin
            bad_rd       <= bad_rd + 1;
            meas_rd_data <= 8'hEE;
         end else begin
            meas_rd_data <= ram[int'(meas_rd_addr)];
         end
      end
   end

   task automatic kick_job(input bit with_start);
      if (with_start) tx_q.push_back(8'h01);
      tx_q.push_back(8'h02);
      for (int i = 0; i < MEAS_BYTES; i++) tx_q.push_back(ram[i]);
      job_start = 1'b1;
      @(posedge clk); #1;
      job_start = 1'b0;
   endtask

   task automatic build_frame(input logic [7:0] it, input logic [15:0] cyc, input logic [7:0] base);
      rx_q.delete();
      corr_q.delete();
      rx_q.push_back(it);
      rx_q.push_back(cyc[15:8]);
      rx_q.push_back(cyc[7:0]);
      for (int i = 0; i < CORR_BYTES; i++) begin
         rx_q.push_back(base + 8'(i));
         corr_q.push_back({8'(i), base + 8'(i)});
      end
      exp_iter = it;
      exp_cyc  = cyc;
   endtask

   // Streams the tx side until the scoreboard drains (or stop_after pops).
   task automatic run_tx(input int ready_pct, input int stop_after, input int pre, input int poke_at);
      int popped = 0;
      int cyc = 0;
      int gap = 0;
      int bubbles = 0;
      bit stalled = 1'b0;
      logic [7:0] held = 8'h00;
      logic [7:0] exp_b;
      while (tx_q.size() != 0 && popped < stop_after && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
               n_err++;
               $display("FAIL tx_hold: valid=%0b data=%02h, expected valid=1 data=%02h", tx_valid, tx_data, held);
            end
         end
         if (tx_valid && tx_ready) begin
            exp_b = tx_q.pop_front();
            n_cmp++;
            if (tx_data !== exp_b) begin
               n_err++;
               $display("FAIL tx_byte[%0d]: got %02h, expected %02h", popped, tx_data, exp_b);
            end
            popped++;
         end else if (!tx_valid && popped >= pre) begin
            if (popped == pre) gap++;
            else bubbles++;
         end
         stalled = tx_valid && !tx_ready;
         held    = tx_data;
         @(posedge clk); #1;
         tx_ready  = ($urandom_range(99) < ready_pct);
         job_start = (poke_at >= 0) && (popped == poke_at);
      end
      job_start = 1'b0;
      n_cmp++;
      if (cyc >= 2000) begin
         n_err++;
         $display("FAIL tx_budget: %0d bytes left after %0d cycles, expected 0", tx_q.size(), cyc);
      end
      n_cmp++;
      if (bubbles != 0) begin
         n_err++;
         $display("FAIL tx_bubbles: got %0d, expected 0", bubbles);
      end
      if (popped > pre) begin
         n_cmp++;
         if (gap > 2) begin
            n_err++;
            $display("FAIL meas_latency: got %0d idle cycles, expected <=2", gap);
         end
      end
      n_cmp++;
      if (bad_rd != 0) begin
         n_err++;
         $display("FAIL ram_range: %0d reads past last address, expected 0", bad_rd);
      end
   endtask

   // Drives rx_q into the DUT and checks corr writes, done pulse and status.
   task automatic run_rx(input int valid_pct, input bit poke_done);
      int idx = 0;
      int cyc = 0;
      int dones = 0;
      int settle = 0;
      int n = rx_q.size();
      bit acc;
      logic [15:0] exp_w;
      tx_ready = 1'b0;
      rx_valid = ($urandom_range(99) < valid_pct);
      rx_data  = rx_q[0];
      while (settle < 4 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (corr_we) begin
            n_cmp++;
            if (corr_q.size() == 0) begin
               n_err++;
               $display("FAIL corr_extra: addr=%0d data=%02h, expected no write", corr_addr, corr_data);
            end else begin
               exp_w = corr_q.pop_front();
               if ({2'b00, corr_addr, corr_data} !== exp_w) begin
                  n_err++;
                  $display("FAIL corr_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                           corr_addr, corr_data, exp_w[15:8], exp_w[7:0]);
               end
            end
         end
         if (job_done) dones++;
         if (dones == 0) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_err++;
               $display("FAIL busy_hold: got %0b, expected 1", busy);
            end
         end
         acc = rx_valid && rx_ready;
         @(posedge clk); #1;
         job_start = 1'b0;
         if (acc) begin
            idx++;
            // lands in the DONE cycle; must be ignored
            if (idx == n && poke_done) job_start = 1'b1;
         end
         if (idx >= n) begin
            rx_valid = 1'b0;
            settle++;
         end else begin
            rx_valid = ($urandom_range(99) < valid_pct);
            rx_data  = rx_q[idx];
         end
      end
      job_start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cyc >= 3000) begin
         n_err++;
         $display("FAIL rx_budget: %0d of %0d bytes accepted, expected all", idx, n);
      end
      n_cmp++;
      if (dones != 1) begin
         n_err++;
         $display("FAIL job_done_count: got %0d, expected 1", dones);
      end
      n_cmp++;
      if (corr_q.size() != 0) begin
         n_err++;
         $display("FAIL corr_missing: %0d writes not seen, expected 0", corr_q.size());
      end
      n_cmp++;
      if (iteration_count !== exp_iter) begin
         n_err++;
         $display("FAIL iteration_count: got %02h, expected %02h", iteration_count, exp_iter);
      end
      n_cmp++;
      if (cycle_count !== exp_cyc) begin
         n_err++;
         $display("FAIL cycle_count: got %04h, expected %04h", cycle_count, exp_cyc);
      end
      n_cmp++;
      if ({busy, job_done, timeout_err, tx_valid} !== 4'b0000) begin
         n_err++;
         $display("FAIL idle_after_done: busy/done/to/tx_valid=%04b, expected 0000",
                  {busy, job_done, timeout_err, tx_valid});
      end
   endtask

   task automatic test_reset();
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, job_done, timeout_err, meas_rd_en, meas_rd_addr, tx_data, tx_valid, rx_ready,
           corr_we, corr_addr, corr_data, iteration_count, cycle_count} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: some output nonzero during reset, expected all 0");
      end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, tx_valid, rx_ready, meas_rd_en, corr_we, iteration_count} !== '0) begin
         n_err++;
         $display("FAIL idle_after_reset: busy=%0b tx_valid=%0b rx_ready=%0b rd_en=%0b iter=%02h, expected 0",
                  busy, tx_valid, rx_ready, meas_rd_en, iteration_count);
      end
      rx_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_first_job();
      for (int i = 0; i < MEAS_BYTES; i++) ram[i] = 8'(i);
      tx_ready = 1'b1;
      kick_job(1'b1);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_on_start: got %0b, expected 1", busy);
      end
      run_tx(100, 1000, 2, -1);
      build_frame(8'h05, 16'h012C, 8'h80);
      run_rx(100, 1'b0);
   endtask

   task automatic test_second_job();
      for (int i = 0; i < MEAS_BYTES; i++) ram[i] = 8'h3C + 8'(3 * i);
      tx_ready = 1'b1;
      kick_job(1'b0);
      run_tx(100, 1000, 1, 5);
      build_frame(8'h11, 16'hBEEF, 8'h20);
      run_rx(100, 1'b1);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < MEAS_BYTES; i++) ram[i] = ~8'(i);
      tx_ready = 1'b1;
      kick_job(1'b0);
      run_tx(50, 1000, 1, -1);
      build_frame(8'hFF, 16'hA55A, 8'hD8);
      run_rx(60, 1'b0);
   endtask

   task automatic test_timeout();
      int w = 0;
      for (int i = 0; i < MEAS_BYTES; i++) ram[i] = 8'hC0 ^ 8'(i);
      tx_ready = 1'b1;
      kick_job(1'b0);
      run_tx(100, 1000, 1, -1);
      tx_ready = 1'b0;
      rx_data  = 8'h07;
      rx_valid = 1'b1;
      do begin
         @(negedge clk);
         w++;
      end while (!rx_ready && w < 20);
      n_cmp++;
      if (rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rx_wait: rx_ready=%0b after %0d cycles, expected 1", rx_ready, w);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      for (int k = 1; k <= TO_CYC; k++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (k < TO_CYC) begin
            if ({timeout_err, busy} !== 2'b01) begin
               n_err++;
               $display("FAIL timeout_early[%0d]: err/busy=%02b, expected 01", k, {timeout_err, busy});
            end
         end else if ({timeout_err, busy, rx_ready, job_done} !== 4'b1000) begin
            n_err++;
            $display("FAIL timeout_fire: err/busy/rx_ready/done=%04b, expected 1000",
                     {timeout_err, busy, rx_ready, job_done});
         end
      end
      n_cmp++;
      if (iteration_count !== 8'h07) begin
         n_err++;
         $display("FAIL timeout_iter: got %02h, expected 07", iteration_count);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      kick_job(1'b1);
      n_cmp++;
      if ({timeout_err, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL timeout_clear: err/busy=%02b, expected 01", {timeout_err, busy});
      end
      run_tx(100, 1000, 2, -1);
      build_frame(8'h02, 16'h0100, 8'h00);
      run_rx(100, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < MEAS_BYTES; i++) ram[i] = 8'h90 + 8'(i);
      tx_ready = 1'b1;
      kick_job(1'b0);
      run_tx(100, 12, 1, -1);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({tx_valid, meas_rd_en, busy, rx_ready} !== 4'b0000) begin
         n_err++;
         $display("FAIL async_abort: tx_valid/rd_en/busy/rx_ready=%04b, expected 0000",
                  {tx_valid, meas_rd_en, busy, rx_ready});
      end
      tx_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, job_done, timeout_err, meas_rd_en, meas_rd_addr, tx_data, tx_valid, rx_ready,
           corr_we, corr_addr, corr_data, iteration_count, cycle_count} !== '0) begin
         n_err++;
         $display("FAIL post_abort_outputs: some output nonzero, expected all 0");
      end
      @(posedge clk); #1;
      kick_job(1'b1);
      run_tx(100, 1000, 2, -1);
      build_frame(8'h33, 16'h0042, 8'h61);
      run_rx(80, 1'b0);
   endtask

   initial begin
      test_reset();
      test_first_job();
      test_second_job();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
